// File: rtl/nios2_debug_mem_arbiter.sv
// nios2_debug_mem_arbiter: round-robin arbiter for the 256x32 debug RAM between the CPU port and JTAG strobes.
// Define DEBUG_MEM_WRITE_PROTECT_EN to block CPU writes to the upper half unless debugack is high.
module nios2_debug_mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_writedata,
   input  logic [3:0]        cpu_byteenable,
   output logic [31:0]       cpu_readdata,
   output logic              cpu_waitrequest,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [37:0]       jdo,
   input  logic              debugack,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_be,
   input  logic [31:0]       ram_rdata
);
   typedef enum logic [1:0] {IDLE, WR, RD, RDDATA} state_t;
   state_t            state;
   logic              owner_jtag, last_jtag;
   logic              jtag_pending, jtag_wr, jtag_inc;
   logic [31:0]       jtag_wdata, rd_q;
   logic [ADDR_W-1:0] jtag_addr;
   logic [3:0]        lat_cnt;
   logic              cpu_req, done, cpu_done, jtag_done, jtag_free, grant_cpu, wr_blocked;
   logic              unused_bits;
   assign cpu_req   = cpu_read | cpu_write;
   assign done      = (state == WR) || (state == RDDATA);
   assign cpu_done  = done && !owner_jtag;
   assign jtag_done = done && owner_jtag;
   assign jtag_free = !jtag_pending || jtag_done;
   assign grant_cpu = cpu_req && (!jtag_pending || last_jtag);
`ifdef DEBUG_MEM_WRITE_PROTECT_EN
   assign wr_blocked = cpu_address[ADDR_W-1] && !debugack;
`else
   assign wr_blocked = 1'b0;
`endif
   assign unused_bits     = ^{jdo[36], jdo[34:32], debugack};
   assign cpu_waitrequest = cpu_req && !cpu_done;
   assign cpu_readdata    = (state == RDDATA && !owner_jtag) ? ram_rdata : rd_q;
   assign monitor_ready   = !jtag_pending;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         owner_jtag    <= 1'b0;
         last_jtag     <= 1'b1;
         jtag_pending  <= 1'b0;
         jtag_wr       <= 1'b0;
         jtag_inc      <= 1'b0;
         jtag_wdata    <= '0;
         jtag_addr     <= '0;
         monitor_error <= 1'b0;
         MonDReg       <= '0;
         rd_q          <= '0;
         ram_addr      <= '0;
         ram_wr        <= 1'b0;
         ram_wdata     <= '0;
         ram_be        <= '0;
         lat_cnt       <= '0;
      end else begin
         ram_wr <= 1'b0;
         if (jtag_done) begin
            jtag_pending <= 1'b0;
            if (jtag_wr && jtag_inc) jtag_addr <= jtag_addr + ADDR_W'(1);
         end
         if (state == RDDATA && owner_jtag) MonDReg <= ram_rdata;
         if (state == RDDATA && !owner_jtag) rd_q <= ram_rdata;
         // a strobe may land in the completing cycle of the previous operation
         if (take_action_ocimem_a) begin
            if (jtag_free) begin
               jtag_pending <= 1'b1;
               jtag_wr      <= 1'b0;
               jtag_addr    <= jdo[ADDR_W-1:0];
               if (jdo[37]) monitor_error <= 1'b0;
            end else monitor_error <= 1'b1;
         end
         if (take_action_ocimem_b) begin
            if (jtag_free && !take_action_ocimem_a) begin
               jtag_pending <= 1'b1;
               jtag_wr      <= 1'b1;
               jtag_wdata   <= jdo[31:0];
               jtag_inc     <= jdo[35];
            end else monitor_error <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  owner_jtag <= 1'b0;
                  last_jtag  <= 1'b0;
                  ram_addr   <= cpu_address;
                  ram_wdata  <= cpu_writedata;
                  ram_be     <= cpu_byteenable;
                  ram_wr     <= cpu_write && !wr_blocked;
                  state      <= cpu_write ? WR : RD;
               end else if (jtag_pending) begin
                  owner_jtag <= 1'b1;
                  last_jtag  <= 1'b1;
                  ram_addr   <= jtag_addr;
                  ram_wdata  <= jtag_wdata;
                  ram_be     <= 4'hF;
                  ram_wr     <= jtag_wr;
                  state      <= jtag_wr ? WR : RD;
               end
            end
            WR: state <= IDLE;
            RD: begin
               lat_cnt <= (lat_cnt == 4'(RD_LAT - 1)) ? 4'd0 : lat_cnt + 4'd1;
               state   <= (lat_cnt == 4'(RD_LAT - 1)) ? RDDATA : RD;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nios2_debug_mem_arbiter.sv
// tb_nios2_debug_mem_arbiter: directed self-checking bench with a behavioural one-cycle-latency RAM.
module tb_nios2_debug_mem_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic [7:0]  cpu_address = '0;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [31:0] cpu_writedata = '0;
   logic [3:0]  cpu_byteenable = '0;
   logic [31:0] cpu_readdata;
   logic        cpu_waitrequest;
   logic        take_a = 1'b0, take_b = 1'b0;
   logic [37:0] jdo = '0;
   logic        debugack = 1'b0;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;
   logic [7:0]  ram_addr;
   logic        ram_wr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic [31:0] ram_rdata = '0;
   logic [31:0] mem [256] = '{default: 32'h0};
   int          checks = 0, errors = 0, waits;
   logic [31:0] rd, wp_exp;
   nios2_debug_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
      .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
      .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b), .jdo(jdo),
      .debugack(debugack), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
      .monitor_error(monitor_error), .ram_addr(ram_addr), .ram_wr(ram_wr),
      .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (ram_wr)
         for (int i = 0; i < 4; i++)
            if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= mem[ram_addr];
   end
   task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic cpu_access(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, output int nw, output logic [31:0] data);
      cpu_read = r; cpu_write = w; cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
      nw = 0;
      #1;
      while (cpu_waitrequest && nw < 20) begin
         @(negedge clk); #1;
         nw++;
      end
      data = cpu_readdata;
      @(negedge clk);
      cpu_read = 1'b0; cpu_write = 1'b0;
   endtask
   task automatic jtag_strobe(input logic is_b, input logic [37:0] j);
      jdo = j; take_a = !is_b; take_b = is_b;
      @(negedge clk);
      take_a = 1'b0; take_b = 1'b0;
   endtask
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!monitor_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, monitor_ready, 1);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ram_wr", ram_wr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ready", monitor_ready, 1);
      chk("rst_error", monitor_error, 0);
      chk("rst_mondreg", MonDReg, 0);
      chk("rst_readdata", cpu_readdata, 0);
      chk("rst_wait_idle", cpu_waitrequest, 0);
      cpu_read = 1'b1; #1;
      chk("rst_wait_req", cpu_waitrequest, 1);
      cpu_read = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      cpu_access(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, waits, rd);
      chk("cpu_wr_waits", waits, 1);
      chk("cpu_wr_mem", mem[8'h10], 32'hDEADBEEF);
      cpu_access(1, 0, 8'h10, 32'h0, 4'hF, waits, rd);
      chk("cpu_rd_waits", waits, 2);
      chk("cpu_rd_data", rd, 32'hDEADBEEF);
      cpu_access(1, 1, 8'h11, 32'hA5A5A5A5, 4'b0101, waits, rd);
      chk("rw_both_waits", waits, 1);
      chk("rw_both_mem", mem[8'h11], 32'h00A500A5);
      jtag_strobe(0, 38'h0FF);
      chk("ja_busy", monitor_ready, 0);
      wait_ready("ja_ready");
      jtag_strobe(1, {6'b001000, 32'h12345678});
      wait_ready("jb_ready");
      chk("jb_mem_ff", mem[8'hFF], 32'h12345678);
      jtag_strobe(1, {6'b000000, 32'hCAFEF00D});
      wait_ready("jb2_ready");
      chk("jb_wrap_mem0", mem[8'h00], 32'hCAFEF00D);
      jtag_strobe(0, 38'h0FF);
      chk("ja2_busy", monitor_ready, 0);
      wait_ready("ja2_ready");
      chk("ja2_mondreg", MonDReg, 32'h12345678);
      cpu_read = 1'b1; cpu_address = 8'h10; take_a = 1'b1; jdo = 38'h011;
      @(negedge clk); take_a = 1'b0;
      chk("sim_cpu_first", ram_addr, 8'h10);
      chk("sim_cpu_wait", cpu_waitrequest, 1);
      @(negedge clk);
      chk("sim_cpu_data", cpu_readdata, 32'hDEADBEEF);
      chk("sim_cpu_done", cpu_waitrequest, 0);
      cpu_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sim_jtag_next", ram_addr, 8'h11);
      chk("sim_jtag_busy", monitor_ready, 0);
      wait_ready("sim_ready");
      chk("sim_mondreg", MonDReg, 32'h00A500A5);
      take_a = 1'b1; jdo = 38'h011;
      @(negedge clk); take_a = 1'b0; cpu_read = 1'b1; cpu_address = 8'h10;
      @(negedge clk);
      chk("rr1_cpu", ram_addr, 8'h10);
      repeat (3) @(negedge clk);
      chk("rr2_jtag", ram_addr, 8'h11);
      chk("rr2_cpu_waits", cpu_waitrequest, 1);
      @(negedge clk); take_a = 1'b1; jdo = 38'h011;
      @(negedge clk); take_a = 1'b0;
      chk("rr_same_cycle_err", monitor_error, 0);
      chk("rr_same_cycle_pend", monitor_ready, 0);
      @(negedge clk);
      chk("rr3_cpu", ram_addr, 8'h10);
      repeat (3) @(negedge clk);
      chk("rr4_jtag", ram_addr, 8'h11);
      cpu_read = 1'b0;
      wait_ready("rr_ready");
      cpu_read = 1'b1; cpu_address = 8'h10;
      @(negedge clk); take_a = 1'b1; jdo = 38'h011;
      @(negedge clk); take_a = 1'b0;
      chk("ov_cpu_done", cpu_waitrequest, 0);
      cpu_read = 1'b0;
      @(negedge clk); take_a = 1'b1; jdo = 38'h012;
      @(negedge clk); take_a = 1'b0;
      chk("ov_error_set", monitor_error, 1);
      wait_ready("ov_ready");
      chk("ov_error_sticky", monitor_error, 1);
      jtag_strobe(0, {1'b1, 37'h011});
      chk("ov_error_clear", monitor_error, 0);
      wait_ready("ov_clear_ready");
`ifdef DEBUG_MEM_WRITE_PROTECT_EN
      wp_exp = 32'h0;
`else
      wp_exp = 32'hAA;
`endif
      cpu_access(0, 1, 8'h80, 32'hAA, 4'hF, waits, rd);
      chk("wp_waits", waits, 1);
      chk("wp_mem_blocked", mem[8'h80], wp_exp);
      debugack = 1'b1;
      cpu_access(0, 1, 8'h80, 32'hBB, 4'hF, waits, rd);
      chk("wp_mem_debug", mem[8'h80], 32'hBB);
      debugack = 1'b0;
      cpu_write = 1'b1; cpu_address = 8'h40; cpu_writedata = 32'h55; cpu_byteenable = 4'hF;
      take_a = 1'b1; jdo = 38'h011;
      @(negedge clk); take_a = 1'b0;
      chk("rm_wr_before", ram_wr, 1);
      reset = 1'b1; #1;
      chk("rm_wr_off", ram_wr, 0);
      chk("rm_pending_drop", monitor_ready, 1);
      cpu_write = 1'b0;
      repeat (2) @(negedge clk);
      chk("rm_mem_untouched", mem[8'h40], 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_ram_addr", ram_addr, 0);
      chk("post_ram_wdata", ram_wdata, 0);
      chk("post_ram_be", ram_be, 0);
      chk("post_ram_wr", ram_wr, 0);
      chk("post_mondreg", MonDReg, 0);
      chk("post_readdata", cpu_readdata, 0);
      chk("post_error", monitor_error, 0);
      chk("post_ready", monitor_ready, 1);
      chk("post_wait", cpu_waitrequest, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nios2_debug_mem_arbiter.md
# nios2_debug_mem_arbiter

Arbitrates single-port access to the 256×32 on-chip debug memory between the CPU's memory-mapped debug port and the JTAG debug slave command strobes. Sits beside the debug slave: consumes `take_action_ocimem_a/b` and `jdo`, returns `MonDReg` and `monitor_ready`, and sequences all RAM reads and writes through one FSM with round-robin fairness.

## Interface
- `ADDR_W`, default 8: debug RAM word-address width.
- `RD_LAT`, default 1: RAM read latency in cycles; only 1 is supported.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_address` in 8: CPU word address.
- `cpu_read` in 1: CPU read request, held until accepted.
- `cpu_write` in 1: CPU write request, held until accepted.
- `cpu_writedata` in 32: CPU write data.
- `cpu_byteenable` in 4: CPU byte enables.
- `cpu_readdata` out 32: CPU read data.
- `cpu_waitrequest` out 1: Avalon-style stall.
- `take_action_ocimem_a` in 1: JTAG strobe: load address and queue a read.
- `take_action_ocimem_b` in 1: JTAG strobe: queue a write.
- `jdo` in 38: JTAG data-out word.
- `debugack` in 1: CPU is in debug mode.
- `MonDReg` out 32: last JTAG read result.
- `monitor_ready` out 1: no JTAG operation pending.
- `monitor_error` out 1: sticky overrun flag.
- `ram_addr` out 8: RAM address.
- `ram_wr` out 1: RAM write strobe.
- `ram_wdata` out 32: RAM write data.
- `ram_be` out 4: RAM byte enables.
- `ram_rdata` in 32: RAM read data, valid one cycle after the address is presented.

## Operation
**JTAG command decode**
- `take_action_ocimem_a`:
  - `jtag_addr <= jdo[7:0]`.
  - Queue a read.
  - If `jdo[37]` is set, clear `monitor_error`.
- `take_action_ocimem_b`:
  - Queue a write of `jdo[31:0]` to `jtag_addr`, with `be = 4'hF`.
  - After the write, `jtag_addr` increments (wrapping 255→0) when `jdo[35]` is set.
- One JTAG operation may be pending at a time. A strobe arriving while one is pending is dropped and sets `monitor_error`, which stays set until cleared.
- If both strobes assert in the same cycle, `a` wins and `b` is dropped with `monitor_error` set.

**FSM states:** IDLE, WR, RD, RDDATA.
- IDLE:
  - Requesters are the CPU (`cpu_read|cpu_write`) and the JTAG pending operation.
  - With one requester, grant it. With both, grant the one not granted last (round-robin). `last_grant` resets to JTAG, so the CPU wins the first tie.
  - Latch owner, address, data and byte enables. Go to WR or RD.
- WR:
  - `ram_wr=1` with the latched address, data and byte enables.
  - CPU owner: `cpu_waitrequest=0` this cycle.
  - JTAG owner: pending is cleared at the end of the cycle.
  - Next state: IDLE.
- RD: `ram_addr` is driven with the latched address and `ram_wr=0`. Next state: RDDATA.
- RDDATA:
  - CPU owner: `cpu_readdata=ram_rdata` and `cpu_waitrequest=0`.
  - JTAG owner: `MonDReg <= ram_rdata` and pending is cleared.
  - Next state: IDLE.
- `cpu_waitrequest` is 1 whenever a CPU request is present and is not in its completing cycle. When no CPU request is present it is 0.
- `monitor_ready = !jtag_pending`.

## Timing
**Reset values**
- FSM=IDLE, `jtag_pending=0`, `monitor_error=0`, `MonDReg=0`, `jtag_addr=0`, `cpu_readdata=0`.
- `ram_wr=0`, `ram_addr=0`, `ram_wdata=0`, `ram_be=0`.
- `monitor_ready=1`.
- `cpu_waitrequest` equals `cpu_read|cpu_write`.

**Latency from request sampled in IDLE at edge N**
- Write completes in the cycle after edge N: 1 wait cycle.
- Read data is valid in the cycle after edge N+1: 2 wait cycles.
- A losing requester waits at most one full transaction (2 or 3 cycles) plus its own transaction.

**Boundary conditions**
- Reset asserted mid-transaction aborts immediately. No `ram_wr` pulse occurs while `reset` is high. A pending JTAG operation is discarded.
- A JTAG strobe arriving in the same cycle its pending operation completes is accepted, with no overrun.
- Address wrap: `jtag_addr` 255 + increment gives 0. `cpu_address` is never modified.
- `cpu_read` and `cpu_write` both high is treated as a write.

## Configuration
- `DEBUG_MEM_WRITE_PROTECT_EN` defined:
  - A CPU write to `address[7]=1` while `debugack=0` is completed normally (WR state, waitrequest drops), but `ram_wr` stays 0.
  - JTAG writes are never blocked.
- `DEBUG_MEM_WRITE_PROTECT_EN` undefined: all CPU writes reach the RAM.

## Test plan
- **CPU write then read:** CPU writes `0xDEADBEEF` @0x10, then reads @0x10 → 1 wait cycle on the write; read returns `0xDEADBEEF` after 2 wait cycles.
- **JTAG write then read:** `ocimem_b` with `jdo[31:0]=0x12345678`, `jdo[35]=1`, `jtag_addr=0xFF` → RAM[0xFF] written; `jtag_addr` becomes 0. Then `ocimem_a` with `jdo[7:0]=0xFF` → `MonDReg=0x12345678`; `monitor_ready` is low during the read and back to 1 after.
- **Simultaneous requests:** CPU read and JTAG read both requested from reset in the same cycle → CPU is served first, JTAG next. Repeat with continuous requests → grants alternate.
- **Overrun:** two `ocimem_a` strobes 1 cycle apart while a CPU read is in flight → second strobe dropped, `monitor_error=1`. A later `ocimem_a` with `jdo[37]=1` → `monitor_error` returns to 0.
- **Reset mid-write:** assert `reset` during WR → `ram_wr=0` immediately; after release, all outputs hold their reset values.
- **Write protect** (`DEBUG_MEM_WRITE_PROTECT_EN`): CPU write `0xAA` @0x80 with `debugack=0` → `ram_wr` never asserts and waitrequest drops. Same write with `debugack=1` → RAM written.
